// File: rtl/temporal_edge_encoder_pkg.sv
// Shared definitions for the temporal edge encoder: gamma sizing, FSM encoding and
// count width helpers.
package temporal_pkg;

   localparam int unsigned GAMMA_CYCLE_WIDTH_DEF = 16;

   // Guard against $clog2(1) == 0 so a count register always has at least one bit.
   function automatic int unsigned count_width(input int unsigned gamma_width);
      return (gamma_width < 2) ? 1 : $clog2(gamma_width);
   endfunction

   localparam int unsigned COUNT_WIDTH_DEF = count_width(GAMMA_CYCLE_WIDTH_DEF);

   typedef logic [COUNT_WIDTH_DEF-1:0] count_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } enc_state_t;

endpackage

// File: rtl/temporal_edge_encoder_gamma_counter.sv
// Gamma phase counter: synchronous clear, count enable and a terminal flag on the
// last cycle of the gamma.
module gamma_counter
   import temporal_pkg::*;
#(
   parameter int unsigned GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
   localparam int unsigned CW = count_width(GAMMA_CYCLE_WIDTH)
) (
   input  logic          aclk,
   input  logic          grst_n,
   input  logic          load,
   input  logic          enable,
   output logic [CW-1:0] count,
   output logic          terminal
);

   logic [CW-1:0] count_q;

   always_ff @(posedge aclk or negedge grst_n) begin
      if (!grst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + CW'(1);
      end
   end

   assign count    = count_q;
   assign terminal = (count_q == CW'(GAMMA_CYCLE_WIDTH - 1));

endmodule

// File: rtl/temporal_edge_encoder.sv
// Encodes per-lane binary values as rising edges within a gamma cycle; value v rises
// at gamma_count == v and holds until the gamma ends.
module temporal_edge_encoder
   import temporal_pkg::*;
#(
   parameter int unsigned GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
   parameter int unsigned NUM_LANES         = 4,
   parameter int unsigned VALUE_WIDTH       = count_width(GAMMA_CYCLE_WIDTH),
   localparam int unsigned CW = count_width(GAMMA_CYCLE_WIDTH)
) (
   input  logic                                  aclk,
   input  logic                                  grst_n,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [NUM_LANES-1:0][VALUE_WIDTH-1:0] in_values,
   input  logic [NUM_LANES-1:0]                  in_null,
   output logic                                  gamma_start,
   output logic [CW-1:0]                         gamma_count,
   output logic [NUM_LANES-1:0]                  edges,
   output logic                                  busy
);

   localparam int unsigned CMP_W = ((VALUE_WIDTH > CW) ? VALUE_WIDTH : CW) + 1;

   enc_state_t       state_q, state_d;
   logic             gamma_start_q;
   logic             terminal;
   logic             last_cycle;
   logic             advance;
   logic             accept;
   logic [CMP_W-1:0] next_idx;

   assign last_cycle = (state_q == RUN) & terminal;
   assign advance    = (state_q == RUN) & ~terminal;
   assign in_ready   = (state_q == IDLE) | last_cycle;
   assign accept     = in_valid & in_ready;
   // Widened so the index one past the current count never wraps into a small value.
   assign next_idx   = CMP_W'(gamma_count) + CMP_W'(1);

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = RUN;
      end else if (last_cycle) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge aclk or negedge grst_n) begin
      if (!grst_n) begin
         state_q       <= IDLE;
         gamma_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         gamma_start_q <= accept;
      end
   end

   gamma_counter #(
      .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)
   ) u_gamma_counter (
      .aclk    (aclk),
      .grst_n  (grst_n),
      .load    (accept | last_cycle),
      .enable  (advance),
      .count   (gamma_count),
      .terminal(terminal)
   );

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic [VALUE_WIDTH-1:0] val_q;
      logic                   null_q;
      logic                   edge_q, edge_d;
      logic                   hit;

      always_ff @(posedge aclk or negedge grst_n) begin
         if (!grst_n) begin
            val_q  <= '0;
            null_q <= 1'b0;
         end else if (accept) begin
            val_q  <= in_values[i];
            null_q <= in_null[i];
         end
      end

      // Values >= GAMMA_CYCLE_WIDTH never match an in-gamma index, so they act as null.
      assign hit = ~null_q & (CMP_W'(val_q) == next_idx);

      always_comb begin
         edge_d = edge_q;
         if (accept) begin
            edge_d = ~in_null[i] & (in_values[i] == '0);
         end else if (advance) begin
            edge_d = edge_q | hit;
         end else if (last_cycle) begin
            edge_d = 1'b0;
         end
      end

      always_ff @(posedge aclk or negedge grst_n) begin
         if (!grst_n) begin
            edge_q <= 1'b0;
         end else begin
            edge_q <= edge_d;
         end
      end

      assign edges[i] = edge_q;
   end

   assign gamma_start = gamma_start_q;
   assign busy        = (state_q == RUN);

endmodule

// File: tb/tb_temporal_edge_encoder.sv
// Bench for temporal_edge_encoder: phase-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_temporal_edge_encoder;

   localparam int unsigned G = 16;
   localparam int unsigned L = 4;

   logic            aclk = 1'b0;
   logic            grst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [L-1:0][3:0] in_values = '0;
   logic [L-1:0]    in_null = '0;
   logic            gamma_start;
   logic [3:0]      gamma_count;
   logic [L-1:0]    edges;
   logic            busy;

   int total = 0;
   int bad = 0;
   int cycle = 0;
   int prev_start = -1;
   int last_start = -1;

   temporal_edge_encoder #(
      .GAMMA_CYCLE_WIDTH(G),
      .NUM_LANES        (L),
      .VALUE_WIDTH      (4)
   ) dut (
      .aclk       (aclk),
      .grst_n     (grst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_values  (in_values),
      .in_null    (in_null),
      .gamma_start(gamma_start),
      .gamma_count(gamma_count),
      .edges      (edges),
      .busy       (busy)
   );

   always #5 aclk = ~aclk;

   // Reference model: a gamma is "active" with a phase; lane fires once phase >= value.
   logic         m_active;
   int           m_phase;
   logic         m_start;
   int           m_v [L];
   logic [L-1:0] m_null;

   always @(posedge aclk or negedge grst_n) begin
      if (!grst_n) begin
         m_active <= 1'b0;
         m_phase  <= 0;
         m_start  <= 1'b0;
      end else if (in_valid && (!m_active || m_phase == G - 1)) begin
         m_active <= 1'b1;
         m_phase  <= 0;
         m_start  <= 1'b1;
         for (int i = 0; i < L; i++) m_v[i] <= int'(in_values[i]);
         m_null   <= in_null;
      end else if (m_active && m_phase == G - 1) begin
         m_active <= 1'b0;
         m_phase  <= 0;
         m_start  <= 1'b0;
      end else begin
         m_phase  <= m_active ? m_phase + 1 : 0;
         m_start  <= 1'b0;
      end
   end

   function automatic logic [L-1:0] m_edges();
      logic [L-1:0] e;
      for (int i = 0; i < L; i++)
         e[i] = m_active && !m_null[i] && (m_v[i] < G) && (m_v[i] <= m_phase);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cycle, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge aclk) begin
      cycle++;
      if (gamma_start) begin
         prev_start = last_start;
         last_start = cycle;
      end
      check("mdl_edges", 32'(edges), 32'(m_edges()));
      check("mdl_busy", 32'(busy), 32'(m_active));
      check("mdl_start", 32'(gamma_start), 32'(m_start));
      check("mdl_count", 32'(gamma_count), m_active ? 32'(m_phase) : 32'd0);
      check("mdl_ready", 32'(in_ready), 32'(!m_active || m_phase == G - 1));
   end

   // Offer a value set (lane 0 in the low nibble); returns after the accepting edge.
   task automatic offer(input logic [15:0] vals, input logic [L-1:0] nul, output int waits);
      logic ok;
      ok = 1'b0;
      waits = 0;
      in_valid = 1'b1;
      for (int i = 0; i < L; i++) in_values[i] = vals[i*4 +: 4];
      in_null = nul;
      for (int k = 0; k < 64; k++) begin
         @(negedge aclk);
         waits++;
         if (in_ready) begin
            @(posedge aclk);
            #1;
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      if (!ok) check("offer_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_count(input int c);
      for (int k = 0; k < 64; k++) begin
         @(negedge aclk);
         if (busy && gamma_count == 4'(c)) return;
      end
      check("wait_count_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout at cycle %0d", cycle);
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      int rise;
      logic was_busy;
      int mux_in [G];

      // 1: reset
      repeat (3) @(posedge aclk);
      #1;
      check("rst_edges", 32'(edges), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_start", 32'(gamma_start), 32'd0);
      check("rst_count", 32'(gamma_count), 32'd0);
      grst_n = 1'b1;
      @(negedge aclk);
      check("rst_ready", 32'(in_ready), 32'd1);

      // 2: single set {0,5,10,15}
      offer(16'hFA50, 4'b0000, w);
      @(negedge aclk);
      check("t2_start", 32'(gamma_start), 32'd1);
      check("t2_c0", 32'(edges), 32'b0001);
      wait_count(4);
      check("t2_c4", 32'(edges), 32'b0001);
      wait_count(5);
      check("t2_c5", 32'(edges), 32'b0011);
      wait_count(9);
      check("t2_c9", 32'(edges), 32'b0011);
      wait_count(10);
      check("t2_c10", 32'(edges), 32'b0111);
      wait_count(15);
      check("t2_c15", 32'(edges), 32'b1111);
      @(negedge aclk);
      check("t2_idle_edges", 32'(edges), 32'd0);
      check("t2_idle_busy", 32'(busy), 32'd0);

      // 3: null lane 1
      offer(16'h3333, 4'b0010, w);
      wait_count(2);
      check("t3_c2", 32'(edges), 32'b0000);
      wait_count(3);
      check("t3_c3", 32'(edges), 32'b1101);
      wait_count(15);
      check("t3_c15", 32'(edges), 32'b1101);
      @(negedge aclk);

      // 4: back-to-back, A v0=12 then B v0=2
      offer(16'h000C, 4'b1110, w);
      offer(16'h0002, 4'b1110, w);
      @(negedge aclk);
      check("t4_b_c0_count", 32'(gamma_count), 32'd0);
      check("t4_b_c0_fall", 32'(edges[0]), 32'd0);
      @(negedge aclk);
      check("t4_b_c1", 32'(edges[0]), 32'd0);
      @(negedge aclk);
      check("t4_b_c2_rise", 32'(edges[0]), 32'd1);
      check("t4_start_gap", 32'(last_start - prev_start), 32'd16);
      wait_count(15);
      @(negedge aclk);

      // 5: backpressure, new set offered at count 4
      offer(16'h0001, 4'b1110, w);
      wait_count(4);
      check("t5_ready_c4", 32'(in_ready), 32'd0);
      offer(16'h0000, 4'b1110, w);
      check("t5_waits", 32'(w), 32'd11);
      @(negedge aclk);
      check("t5_start", 32'(gamma_start), 32'd1);
      check("t5_edges", 32'(edges), 32'b0001);
      wait_count(15);
      @(negedge aclk);

      // 6: reset mid-gamma at count 7
      offer(16'h0000, 4'b0000, w);
      wait_count(7);
      #2;
      grst_n = 1'b0;
      #1;
      check("t6_async_edges", 32'(edges), 32'd0);
      check("t6_async_busy", 32'(busy), 32'd0);
      check("t6_async_count", 32'(gamma_count), 32'd0);
      repeat (2) @(posedge aclk);
      #1;
      grst_n = 1'b1;
      @(negedge aclk);
      check("t6_ready", 32'(in_ready), 32'd1);
      offer(16'h4321, 4'b0000, w);
      @(negedge aclk);
      check("t6_start", 32'(gamma_start), 32'd1);
      wait_count(2);
      check("t6_c2", 32'(edges), 32'b0011);
      wait_count(15);
      @(negedge aclk);

      // 7: edges[0] with v=10 steering a temporal mux whose inputs[k]=k
      for (int k = 0; k < G; k++) mux_in[k] = k;
      rise = -1;
      was_busy = 1'b0;
      offer(16'h000A, 4'b1110, w);
      for (int k = 0; k < 40; k++) begin
         @(negedge aclk);
         if (busy) was_busy = 1'b1;
         if (busy && edges[0] && rise < 0) rise = int'(gamma_count);
         if (was_busy && !busy) break;
      end
      check("t7_mux_y", (rise >= 0) ? 32'(mux_in[rise]) : 32'hFFFF_FFFF, 32'd10);

      repeat (2) @(negedge aclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
